// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES-128 cipher/inverse-cipher round controllers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: controller state enum, round-phase encodings, default geometry
// constants and a counter-width helper.
package aes_ctrl_pkg;

  // Controller states. LOAD means at least one input beat of the block is held.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYEXP = 3'd1,
    ST_SAVE   = 3'd2,
    ST_READY  = 3'd3,
    ST_LOAD   = 3'd4,
    ST_ROUND  = 3'd5,
    ST_OUT    = 3'd6
  } ctrl_state_t;

  // A round spans three cycles: s-box lookup issue, BRAM read, AddRoundKey.
  localparam int         PHASES  = 3;
  localparam logic [1:0] PH_SUB  = 2'd0;
  localparam logic [1:0] PH_BRAM = 2'd1;
  localparam logic [1:0] PH_ARK  = 2'd2;

  // Default block geometry for AES-128 on the 4-BRAM datapath.
  localparam int DEF_ROUNDS    = 10;
  localparam int DEF_IN_BEATS  = 2;
  localparam int DEF_OUT_BEATS = 3;

  // Width of a counter that must be able to hold the value max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/aes_round_seq.sv
// Round/phase sequencer: phase counts 0..PHASES-1, round advances on phase wrap.
// Latency: counters update on the clock edge after en/clr is sampled.
// Backpressure: none; en simply freezes both counters when low.
//
// Ports:
//   clk        clock
//   kill       synchronous active-high reset
//   clr        synchronous clear of phase and round (lower priority than kill)
//   en         advance one phase
//   phase      current phase (PH_SUB, PH_BRAM, PH_ARK)
//   last_phase phase is the final phase of a round
//   last_round round counter is at ROUNDS-1
module aes_round_seq
  import aes_ctrl_pkg::*;
#(
  parameter int ROUNDS = DEF_ROUNDS
) (
  input  logic       clk,
  input  logic       kill,
  input  logic       clr,
  input  logic       en,
  output logic [1:0] phase,
  output logic       last_phase,
  output logic       last_round
);

  localparam int RW = cnt_width(ROUNDS);
  localparam logic [RW-1:0] ROUND_LAST = RW'(ROUNDS - 1);
  localparam logic [1:0]    PHASE_LAST = 2'(PHASES - 1);

  logic [RW-1:0] round;

  assign last_phase = (phase == PHASE_LAST);
  assign last_round = (round == ROUND_LAST);

  always_ff @(posedge clk) begin
    if (kill || clr) begin
      phase <= PH_SUB;
      round <= '0;
    end else if (en) begin
      if (last_phase) begin
        phase <= PH_SUB;
        // Saturate at the final round; the owner leaves the round state
        // on this same edge and clears us before the next block.
        if (!last_round) begin
          round <= round + RW'(1);
        end
      end else begin
        phase <= phase + 2'd1;
      end
    end
  end

endmodule

// File: rtl/aes_128_inv_control_3val.sv
// AES-128 inverse-cipher control FSM: key expansion, reverse-order rounds, output beats.
// Latency: last input beat at cycle T -> init_ark T+1, rounds T+1..T+3*ROUNDS, out beats follow.
// Backpressure: none; requests arriving in a busy state are dropped and flagged on err.
//
// Ports:
//   clk, kill                 clock and synchronous active-high reset
//   key_load, in_en           new-key pulse and ciphertext beat valid
//   key_fwd_en, key_save      forward key-expansion step, copy last round key to shadow
//   key_restore, key_rev_en   reload working key from shadow, inverse key-schedule step
//   init_ark, ark_en          initial / per-round AddRoundKey strobes
//   en_invmixcol              InvMixColumns enable (qualified with ark_en)
//   key_valid, busy           expanded key held, controller occupied
//   out_en, out_last          plaintext beat valid and final beat
//   err                       one-cycle pulse: a request was ignored
module aes_128_inv_control_3val
  import aes_ctrl_pkg::*;
#(
  parameter int ROUNDS    = DEF_ROUNDS,
  parameter int IN_BEATS  = DEF_IN_BEATS,
  parameter int OUT_BEATS = DEF_OUT_BEATS
) (
  input  logic clk,
  input  logic kill,
  input  logic key_load,
  input  logic in_en,
  output logic key_fwd_en,
  output logic key_save,
  output logic key_restore,
  output logic key_rev_en,
  output logic init_ark,
  output logic ark_en,
  output logic en_invmixcol,
  output logic key_valid,
  output logic busy,
  output logic out_en,
  output logic out_last,
  output logic err
);

  localparam int SW  = cnt_width(ROUNDS);
  localparam int IBW = cnt_width(IN_BEATS);
  localparam int OBW = cnt_width(OUT_BEATS);

  localparam logic [SW-1:0]  STEP_LAST = SW'(ROUNDS - 1);
  localparam logic [IBW-1:0] IN_LAST   = IBW'(IN_BEATS - 1);
  localparam logic [OBW-1:0] OUT_LAST  = OBW'(OUT_BEATS - 1);

  ctrl_state_t    state;
  logic [SW-1:0]  step;
  logic [IBW-1:0] in_beat;
  logic [OBW-1:0] out_beat;
  logic           key_valid_q;
  logic           init_ark_q;
  logic           err_q;

  logic [1:0]     phase;
  logic           last_phase;
  logic           last_round;

  // States in which a new key / an input beat may be taken.
  logic key_ok;
  logic beat_ok;
  assign key_ok  = (state == ST_IDLE) || (state == ST_READY) || (state == ST_LOAD);
  assign beat_ok = (state == ST_READY) || (state == ST_LOAD);

  // Counters sit at zero outside ROUND so each block starts at round 0, phase 0.
  aes_round_seq #(
    .ROUNDS (ROUNDS)
  ) u_round_seq (
    .clk        (clk),
    .kill       (kill),
    .clr        (state != ST_ROUND),
    .en         (state == ST_ROUND),
    .phase      (phase),
    .last_phase (last_phase),
    .last_round (last_round)
  );

  always_ff @(posedge clk) begin
    if (kill) begin
      state       <= ST_IDLE;
      step        <= '0;
      in_beat     <= '0;
      out_beat    <= '0;
      key_valid_q <= 1'b0;
      init_ark_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      init_ark_q <= 1'b0;
      // A beat is lost if it arrives outside READY/LOAD or collides with
      // an accepted key_load; a key_load is lost outside IDLE/READY/LOAD.
      err_q <= (in_en && (!beat_ok || key_load)) || (key_load && !key_ok);

      if (key_load && key_ok) begin
        // New key: restart expansion and drop any partially loaded block.
        state       <= ST_KEYEXP;
        step        <= '0;
        in_beat     <= '0;
        key_valid_q <= 1'b0;
      end else begin
        case (state)
          ST_KEYEXP: begin
            if (step == STEP_LAST) begin
              state <= ST_SAVE;
            end else begin
              step <= step + SW'(1);
            end
          end

          ST_SAVE: begin
            state       <= ST_READY;
            key_valid_q <= 1'b1;
          end

          ST_READY, ST_LOAD: begin
            if (in_en) begin
              if (in_beat == IN_LAST) begin
                state      <= ST_ROUND;
                in_beat    <= '0;
                init_ark_q <= 1'b1;
              end else begin
                state   <= ST_LOAD;
                in_beat <= in_beat + IBW'(1);
              end
            end
          end

          ST_ROUND: begin
            if (last_phase && last_round) begin
              state    <= ST_OUT;
              out_beat <= '0;
            end
          end

          ST_OUT: begin
            if (out_beat == OUT_LAST) begin
              state    <= ST_READY;
              out_beat <= '0;
            end else begin
              out_beat <= out_beat + OBW'(1);
            end
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Moore decodes of the registered state and counters.
  assign key_fwd_en   = (state == ST_KEYEXP);
  assign key_save     = (state == ST_SAVE);
  assign key_rev_en   = (state == ST_ROUND) && (phase == PH_SUB);
  assign ark_en       = (state == ST_ROUND) && (phase == PH_ARK);
  // The final inverse round has no InvMixColumns.
  assign en_invmixcol = ark_en && !last_round;
  assign out_en       = (state == ST_OUT);
  assign out_last     = (state == ST_OUT) && (out_beat == OUT_LAST);
  // The working key has walked down to round key 0; reload round key ROUNDS.
  assign key_restore  = (state == ST_OUT) && (out_beat == '0);
  assign busy         = (state == ST_KEYEXP) || (state == ST_SAVE) ||
                        (state == ST_ROUND)  || (state == ST_OUT);
  assign key_valid    = key_valid_q;
  assign init_ark     = init_ark_q;
  assign err          = err_q;

endmodule

// File: tb/tb_aes_128_inv_control_3val.sv
// Testbench for aes_128_inv_control_3val: directed scenarios plus random traffic
// compared every cycle against a timeline model of the controller.
module tb_aes_128_inv_control_3val;

  localparam int R  = 10;
  localparam int IB = 2;
  localparam int OB = 3;

  localparam int M_IDLE  = 0;
  localparam int M_KEY   = 1;
  localparam int M_READY = 2;
  localparam int M_BLOCK = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic kill, key_load, in_en;
  logic key_fwd_en, key_save, key_restore, key_rev_en, init_ark, ark_en;
  logic en_invmixcol, key_valid, busy, out_en, out_last, err;

  aes_128_inv_control_3val #(
    .ROUNDS    (R),
    .IN_BEATS  (IB),
    .OUT_BEATS (OB)
  ) dut (
    .clk          (clk),
    .kill         (kill),
    .key_load     (key_load),
    .in_en        (in_en),
    .key_fwd_en   (key_fwd_en),
    .key_save     (key_save),
    .key_restore  (key_restore),
    .key_rev_en   (key_rev_en),
    .init_ark     (init_ark),
    .ark_en       (ark_en),
    .en_invmixcol (en_invmixcol),
    .key_valid    (key_valid),
    .busy         (busy),
    .out_en       (out_en),
    .out_last     (out_last),
    .err          (err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: the controller as a timeline. m_k is the cycle number inside key
  // expansion (1-based), m_b the cycle number since the last input beat.
  int m_mode  = M_IDLE;
  int m_k     = 0;
  int m_b     = 0;
  int m_beats = 0;
  bit m_kv    = 1'b0;
  bit m_err   = 1'b0;
  bit m_ia    = 1'b0;

  function automatic logic [11:0] model_vec();
    bit fwd, save, restore, rev, ark, imc, bsy, oen, last;
    int ph, rnd;
    fwd = 0; save = 0; restore = 0; rev = 0; ark = 0; imc = 0;
    bsy = 0; oen = 0; last = 0;
    if (m_mode == M_KEY) begin
      bsy  = 1;
      fwd  = (m_k <= R);
      save = (m_k == R + 1);
    end else if (m_mode == M_BLOCK) begin
      bsy = 1;
      if (m_b <= 3 * R) begin
        ph  = (m_b - 1) % 3;
        rnd = (m_b - 1) / 3;
        rev = (ph == 0);
        ark = (ph == 2);
        imc = ark && (rnd < R - 1);
      end else begin
        oen     = 1;
        restore = (m_b == 3 * R + 1);
        last    = (m_b == 3 * R + OB);
      end
    end
    return {fwd, save, restore, rev, m_ia, ark, imc, m_kv, bsy, oen, last, m_err};
  endfunction

  task automatic model_step(input logic kl, input logic ie, input logic k);
    if (k) begin
      m_mode = M_IDLE; m_kv = 0; m_err = 0; m_ia = 0;
      m_k = 0; m_b = 0; m_beats = 0;
      return;
    end
    m_err = 0;
    m_ia  = 0;
    case (m_mode)
      M_IDLE: begin
        m_err = ie;
        if (kl) begin m_mode = M_KEY; m_k = 1; m_kv = 0; end
      end
      M_KEY: begin
        m_err = kl | ie;
        if (m_k == R + 1) begin m_mode = M_READY; m_beats = 0; m_kv = 1; end
        else m_k++;
      end
      M_READY: begin
        if (kl) begin
          m_mode = M_KEY; m_k = 1; m_kv = 0; m_beats = 0; m_err = ie;
        end else if (ie) begin
          m_beats++;
          if (m_beats == IB) begin m_mode = M_BLOCK; m_b = 1; m_ia = 1; m_beats = 0; end
        end
      end
      default: begin
        m_err = kl | ie;
        if (m_b == 3 * R + OB) begin m_mode = M_READY; m_beats = 0; end
        else m_b++;
      end
    endcase
  endtask

  function automatic logic [11:0] dut_vec();
    return {key_fwd_en, key_save, key_restore, key_rev_en, init_ark, ark_en,
            en_invmixcol, key_valid, busy, out_en, out_last, err};
  endfunction

  int fwd_cnt = 0, ark_cnt = 0, imc_cnt = 0, out_cnt = 0, rev_cnt = 0;

  // One cycle: check the present outputs, tally pulses, drive inputs for
  // this cycle, advance the model, then move to the next falling edge.
  task automatic tick(input logic kl, input logic ie, input logic k);
    check_eq("outs", 32'(dut_vec()), 32'(model_vec()));
    if (key_fwd_en)   fwd_cnt++;
    if (ark_en)       ark_cnt++;
    if (en_invmixcol) imc_cnt++;
    if (out_en)       out_cnt++;
    if (key_rev_en)   rev_cnt++;
    kill = k; key_load = kl; in_en = ie;
    model_step(kl, ie, k);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_tallies();
    ark_cnt = 0; imc_cnt = 0; out_cnt = 0; rev_cnt = 0;
  endtask

  initial begin
    kill = 1'b1; key_load = 1'b0; in_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset", 32'(dut_vec()), 32'd0);

    // Beat with no key: rejected, state stays IDLE.
    tick(1'b0, 1'b1, 1'b0);
    check_eq("nokey_err", 32'(err), 32'd1);
    tick(1'b0, 1'b0, 1'b0);
    check_eq("nokey_idle_busy", 32'(busy), 32'd0);

    // Key expansion: key_load at cycle 0.
    fwd_cnt = 0;
    for (int c = 0; c < 20; c++) tick(c == 0, 1'b0, 1'b0);
    check_eq("fwd_cnt", 32'(fwd_cnt), 32'd10);
    check_eq("kv_after_exp", 32'(key_valid), 32'd1);

    // Block decrypt: beats at 20,21; stray beat at 30 during ROUND.
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check_eq("init_ark_22", 32'(init_ark), 32'd1);
    clear_tallies();
    for (int i = 0; i < 33; i++) tick(1'b0, i == 8, 1'b0);
    check_eq("ark_cnt", 32'(ark_cnt), 32'd10);
    check_eq("imc_cnt", 32'(imc_cnt), 32'd9);
    check_eq("rev_cnt", 32'(rev_cnt), 32'd10);
    check_eq("out_cnt", 32'(out_cnt), 32'd3);
    check_eq("ready_busy", 32'(busy), 32'd0);

    // Back-to-back block starting on the first READY cycle.
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check_eq("b2b_init_ark", 32'(init_ark), 32'd1);
    for (int i = 0; i < 33; i++) tick(1'b0, 1'b0, 1'b0);
    check_eq("fwd_no_reassert", 32'(fwd_cnt), 32'd10);

    // Abort: one beat, then a new key; two fresh beats complete a block.
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check_eq("abort_kv", 32'(key_valid), 32'd0);
    for (int i = 0; i < 11; i++) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check_eq("abort_one_beat_no_start", 32'(init_ark), 32'd0);
    tick(1'b0, 1'b1, 1'b0);
    clear_tallies();
    for (int i = 0; i < 33; i++) tick(1'b0, 1'b0, 1'b0);
    check_eq("abort_block_out", 32'(out_cnt), 32'd3);

    // key_load and in_en together in READY: key wins, beat dropped.
    tick(1'b1, 1'b1, 1'b0);
    check_eq("collide_err", 32'(err), 32'd1);
    for (int i = 0; i < 11; i++) tick(1'b0, 1'b0, 1'b0);

    // kill during ROUND phase 1.
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    check_eq("kill_outs", 32'(dut_vec()), 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 399) == 0);
    end
    tick(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
